// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state encoding, the instruction size and the control-flow opcodes.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   localparam logic [31:0] INSTR_BYTES = 32'd4;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Sequential successor; wraps modulo 2^32.
   function automatic logic [31:0] seq_pc(input logic [31:0] pc);
      return pc + INSTR_BYTES;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry {pc, instr} holding register between fetch and decode.
// Flush beats load, load beats consume, so a same-edge reload keeps the entry valid.
module fetch_buffer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_load,
   input  logic        i_consume,
   input  logic        i_flush,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instr,
   output logic        o_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_instr
);

   logic        r_valid;
   logic [31:0] r_pc;
   logic [31:0] r_instr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_pc    <= 32'h0;
         r_instr <= 32'h0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_pc    <= i_pc;
         r_instr <= i_instr;
      end else if (i_consume) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_pc    = r_pc;
   assign o_instr = r_instr;

endmodule

// File: rtl/fetch_sequencer.sv
// PC owner and imem fetch FSM (BOOT/REQ/WAIT/DRAIN) with flush arbitration.
// Optional macro MISALIGN_TRAP_EN: misaligned redirects go to TRAP_VECTOR and pulse misalign_trap.
// Handshakes: a beat transfers on an edge where valid and ready are both high; a request's
// address is held while valid is high and ready is low, unless a flush retargets the pc.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        if_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        trap_valid,
   output logic        misalign_trap,
   output logic [1:0]  o_dbg_state
);

   fetch_state_e r_state;
   logic [31:0]  r_pc;
   logic         r_misalign;

   logic         w_flush;
   logic         w_misalign;
   logic         w_hs;
   logic         w_rsp_take;
   logic [31:0]  w_target;

   assign w_flush = trap_valid | redirect_valid;

`ifdef MISALIGN_TRAP_EN
   assign w_misalign = redirect_valid & ~trap_valid & (redirect_pc[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_target   = (trap_valid | w_misalign) ? TRAP_VECTOR : (redirect_pc & ~32'h3);
   assign w_hs       = imem_req_valid & imem_req_ready;
   assign w_rsp_take = (r_state == WAIT) & imem_rsp_valid;

   // Request only when the buffer can take the result.
   assign imem_req_valid = (r_state == REQ) & (~if_valid | if_ready);
   assign imem_req_addr  = r_pc;
   assign misalign_trap  = r_misalign;
   assign o_dbg_state    = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= BOOT;
         r_pc       <= RESET_VECTOR;
         r_misalign <= 1'b0;
      end else begin
         r_misalign <= w_flush & w_misalign;
         if (w_flush)
            r_pc <= w_target;
         else if (w_rsp_take)
            r_pc <= seq_pc(r_pc);
         case (r_state)
            BOOT:  r_state <= REQ;
            REQ:   if (w_hs) r_state <= w_flush ? DRAIN : WAIT;
            // A flush with no response yet leaves a stale request in flight.
            WAIT:  if (imem_rsp_valid) r_state <= REQ;
                   else if (w_flush)   r_state <= DRAIN;
            DRAIN: if (imem_rsp_valid) r_state <= REQ;
            default: r_state <= BOOT;
         endcase
      end
   end

   fetch_buffer u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_load    (w_rsp_take & ~w_flush),
      .i_consume (if_ready),
      .i_flush   (w_flush),
      .i_pc      (r_pc),
      .i_instr   (imem_rsp_data),
      .o_valid   (if_valid),
      .o_pc      (if_pc),
      .o_instr   (if_instr)
   );

endmodule
